// File: rtl/freq_meter_pkg.sv
// Shared constants for the gated frequency meter.
//  - Active-low seven-segment patterns, bit order g..a (bit 6 = g, bit 0 = a).
//  - BCD digit width and the largest BCD digit value.
package freq_meter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/freq_meter_bcd_seg7_dec.sv
// seg7_dec: one BCD digit to active-low seven-segment pattern.
//  bcd  in   4  BCD digit (codes 10..15 blank the display)
//  seg  out  7  segments g..a, active-low
module seg7_dec
  import freq_meter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: gated frequency meter with BCD count chain and 7-seg outputs.
//  Counts synchronised rising edges of sig_in over GATE_CYCLES clocks, latches
//  the window total into bcd (saturating at all nines with ovf) and decodes it.
//  CLOCK_50    in   1          system clock
//  reset_n     in   1          async active-low reset
//  sig_in      in   1          measured signal, asynchronous
//  hold        in   1          1 = keep displayed result at window end
//  hex         out  7*DIGITS   active-low segments, digit i at [7i+6:7i]
//  bcd         out  4*DIGITS   latched result, digit 0 = units
//  meas_valid  out  1          one-cycle pulse on a new result
//  ovf         out  1          latched result saturated
//  one_hz      out  1          high for the first half of each window
// Optional: define FREQ_METER_LZB_EN for leading-zero blanking.
module freq_meter_bcd
  import freq_meter_pkg::*;
#(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    sig_in,
  input  logic                    hold,
  output logic [7*DIGITS-1:0]     hex,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    meas_valid,
  output logic                    ovf,
  output logic                    one_hz
);

  localparam int unsigned CNT_W = $clog2(GATE_CYCLES);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_HALF = CNT_W'(GATE_CYCLES / 2);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      sig_d;
  logic                      rise;
  logic [CNT_W-1:0]          gate_cnt;
  logic                      gate_end;
  logic [BCD_W*DIGITS-1:0]   cnt_q, cnt_inc, cnt_nx;
  logic                      top_carry;
  logic                      win_ovf_q, win_ovf_nx;
  logic [7*DIGITS-1:0]       seg_raw;

  assign rise     = sync_q[SYNC_STAGES-1] & ~sig_d;
  assign gate_end = (gate_cnt == GATE_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      sig_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt <= '0;
      one_hz   <= 1'b0;
    end else begin
      gate_cnt <= gate_end ? '0 : gate_cnt + CNT_W'(1);
      one_hz   <= (gate_cnt < GATE_HALF);
    end
  end

  // Ripple increment; carry out of the top digit only happens from all nines.
  always_comb begin
    logic c;
    c       = 1'b1;
    cnt_inc = cnt_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (cnt_q[BCD_W*i +: BCD_W] == BCD_NINE) begin
          cnt_inc[BCD_W*i +: BCD_W] = '0;
        end else begin
          cnt_inc[BCD_W*i +: BCD_W] = cnt_q[BCD_W*i +: BCD_W] + 4'd1;
          c = 1'b0;
        end
      end
    end
    top_carry = c;
  end

  // Saturated chain holds all nines, so keeping cnt_q is the saturation.
  assign cnt_nx     = (rise && !win_ovf_q && !top_carry) ? cnt_inc : cnt_q;
  assign win_ovf_nx = win_ovf_q | (rise & top_carry);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      win_ovf_q  <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
      meas_valid <= 1'b0;
    end else if (gate_end) begin
      cnt_q      <= '0;
      win_ovf_q  <= 1'b0;
      meas_valid <= ~hold;
      if (!hold) begin
        bcd <= cnt_nx;
        ovf <= win_ovf_nx;
      end
    end else begin
      cnt_q      <= cnt_nx;
      win_ovf_q  <= win_ovf_nx;
      meas_valid <= 1'b0;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .bcd (bcd[BCD_W*g +: BCD_W]),
      .seg (seg_raw[7*g +: 7])
    );
  end

`ifdef FREQ_METER_LZB_EN
  // Blank from the top down until the first nonzero digit; digit 0 always shown.
  always_comb begin
    logic lead;
    hex  = seg_raw;
    lead = ~ovf;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      if (bcd[BCD_W*i +: BCD_W] != '0) lead = 1'b0;
      if (lead) hex[7*i +: 7] = SEG_BLANK;
    end
  end
`else
  assign hex = seg_raw;
`endif

endmodule
